inst_fetcher: RTL

Sequences the instruction decoder. Fetches one 32-bit instruction at a time from the instruction memory port, presents it to the decoder with `start_decode`, holds it until the decoder issues it, then fetches from the decoder-supplied `next_pc`. On a ROB misprediction it discards the held or in-flight instruction and restarts at `correct_pc`. It sits between the instruction cache/memory interface and the decoder.

---
 rtl/inst_fetcher.sv | 132 +++++++++++++
 1 files changed

// File: rtl/inst_fetcher.sv
// rtl/inst_fetcher.sv - single-instruction fetch sequencer between instruction memory and decoder
module inst_fetcher #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  // instruction memory port
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_done,
  input  logic [31:0] mem_data,
  // decoder port
  output logic [31:0] inst,
  output logic [31:0] inst_addr,
  output logic        start_decode,
  input  logic        issue_signal,
  input  logic        jalr_stall,
  input  logic [31:0] next_pc,
  // ROB flush
  input  logic        wrong_predicted,
  input  logic [31:0] correct_pc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_addr_q, inst_addr_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;

  // The decoder already stalls itself on an unresolved JALR by withholding
  // issue_signal, so HOLD covers that case without looking at this input.
  logic unused_jalr_stall;
  assign unused_jalr_stall = jalr_stall;

  // Outputs are pure decodes of the registered state.
  always_comb begin
    mem_req      = (state_q == REQ) || (state_q == DRAIN);
    mem_addr     = pc_q;
    start_decode = (state_q == HOLD) && rdy_in;
    inst         = inst_q;
    inst_addr    = inst_addr_q;
  end

  // Next-state logic; with rdy_in low every register simply holds.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    inst_d        = inst_q;
    inst_addr_d   = inst_addr_q;
    redirect_pc_d = redirect_pc_q;

    if (rdy_in) begin
      unique case (state_q)
        IDLE: begin
          if (wrong_predicted) begin
            pc_d = correct_pc;
          end
          state_d = REQ;
        end

        REQ: begin
          if (wrong_predicted && mem_done) begin
            // Returning word belongs to the squashed path; refetch at once.
            pc_d    = correct_pc;
            state_d = REQ;
          end else if (wrong_predicted) begin
            // The request in flight cannot be withdrawn, and mem_addr must
            // stay on it, so park the restart PC until the data comes back.
            redirect_pc_d = correct_pc;
            state_d       = DRAIN;
          end else if (mem_done) begin
            inst_d      = mem_data;
            inst_addr_d = pc_q;
            state_d     = HOLD;
          end
        end

        HOLD: begin
          if (wrong_predicted) begin
            // Flush beats issue: the held instruction is dropped.
            pc_d    = correct_pc;
            state_d = REQ;
          end else if (issue_signal) begin
            pc_d    = next_pc;
            state_d = REQ;
          end
        end

        DRAIN: begin
          if (mem_done) begin
            // Stale data is discarded; a flush in this same cycle is the
            // newest and therefore wins over the parked redirect.
            pc_d    = wrong_predicted ? correct_pc : redirect_pc_q;
            state_d = REQ;
          end else if (wrong_predicted) begin
            redirect_pc_d = correct_pc;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      inst_q        <= 32'h0;
      inst_addr_q   <= 32'h0;
      redirect_pc_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      inst_q        <= inst_d;
      inst_addr_q   <= inst_addr_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

endmodule
